mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary plus writeback select for the 16-bit five-stage core.
- Sits directly downstream of the memory stage. Captures the ALU result, data-memory read data and writeback control each cycle.
- Presents the register-file write port and forwarding info to decode/execute.
- Owns the halt-drain state machine that declares the core halted once the halting instruction retires.

Parameters:
- N, 16, datapath width of aluResult and wb_data.
- REG_BITS, 3, register-specifier width.
- HALT_DRAIN, 2, cycles spent in DRAIN before HALTED; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  memory stage holds a real instruction
- aluResult  input  N  ALU result / effective address from memory stage
- mem_data  input  16  data-memory read data (memory stage data_out)
- memToReg  input  1  1 = write back mem_data, 0 = aluResult
- regWrite  input  1  instruction writes the register file
- writeReg  input  REG_BITS  destination register
- halt_in  input  1  instruction is HALT
- stall  input  1  hold MEM/WB contents
- flush  input  1  insert bubble
- wb_valid  output  1  registered valid
- wb_regWrite  output  1  register-file write enable = valid & regWrite
- wb_writeReg  output  REG_BITS  registered destination
- wb_data  output  N  writeback data
- halted  output  1  core halted, sticky
- wb_state  output  2  FSM state: RUN=0, DRAIN=1, HALTED=2

Behaviour:
- Reset, asynchronous: all registered fields 0; FSM=RUN; drain counter 0; halted=0. All outputs read 0 while rst is high.
- Priority at each rising edge: flush > stall > load.
  - flush: valid<=0; other fields don't-care; wb_regWrite must be 0.
  - stall, no flush: every register holds.
  - load: capture in_valid, aluResult, mem_data, memToReg, regWrite, writeReg, halt_in. Latency is exactly 1 cycle.
- Load occurs only in state RUN. In DRAIN and HALTED, load and stall are ignored and valid<=0 every cycle.
- wb_data is combinational from registered fields:
  - memToReg ? zero-extended mem_data : aluResult.
  - mem_data is zero-extended when N>16 and truncated to its low N bits when N<16.
- wb_regWrite is never asserted when valid=0, regardless of the stored regWrite.
- FSM transitions:
  - RUN -> DRAIN on the edge that loads in_valid=1 with halt_in=1 (flush not asserted). That instruction is visible on wb_* for one cycle; its regWrite honoured. Counter loads HALT_DRAIN-1.
  - DRAIN: counter decrements each edge. At 0 -> HALTED next edge. flush/stall have no effect on the counter.
  - HALTED: halted=1, terminal until rst.
- Halt arriving with in_valid=0, or on a flushed edge: ignored.
- Halt arriving while stall=1: ignored until the stall releases and the instruction loads.
- Reset mid-DRAIN or while HALTED: returns to RUN immediately (asynchronous), halted drops to 0 without a clock.

Optional Feature:
- Macro MEMWB_PERF_EN.
- Defined: adds output port retired_count (32 bits).
  - Reset 0.
  - Increments by 1 on each edge that loads in_valid=1 in RUN without flush, including the HALT instruction.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-cycle with no clock -> all outputs 0, wb_state=0, immediately. Release; first edge with in_valid=1, aluResult=16'h1234, memToReg=0, regWrite=1, writeReg=3 -> next cycle wb_data=16'h1234, wb_regWrite=1, wb_writeReg=3.
- Load select: mem_data=16'hBEEF, aluResult=16'h0040, memToReg=1 -> wb_data=16'hBEEF one cycle later. Same edge with in_valid=0 -> wb_regWrite=0.
- Stall/flush: load value 16'h00AA; stall=1 for 3 cycles while inputs change to 16'h0055 -> wb_data stays 16'h00AA. Assert flush and stall together -> wb_valid=0 next cycle.
- Halt drain, HALT_DRAIN=2: HALT loaded at edge t -> wb_state=1 after t, 2 after t+2, halted=1 from t+2 onward. Inputs with in_valid=1 after t -> wb_valid stays 0.
- Halt ignored: halt_in=1 with in_valid=0, or with flush=1 -> wb_state stays 0. Then rst pulse during DRAIN -> wb_state=0, halted=0 asynchronously.
- MEMWB_PERF_EN: 5 valid loads, 1 flushed load, 2 stalled edges -> retired_count=5. Force the counter to 32'hFFFF_FFFF, then 1 more valid load -> count stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select and halt-drain FSM for the 16-bit core.
// Optional retired-instruction counter enabled by defining MEMWB_PERF_EN.
module mem_wb_stage #(
    parameter int unsigned N          = 16,
    parameter int unsigned REG_BITS   = 3,
    parameter int unsigned HALT_DRAIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N-1:0]        aluResult,
    input  logic [15:0]         mem_data,
    input  logic                memToReg,
    input  logic                regWrite,
    input  logic [REG_BITS-1:0] writeReg,
    input  logic                halt_in,
    input  logic                stall,
    input  logic                flush,
    output logic                wb_valid,
    output logic                wb_regWrite,
    output logic [REG_BITS-1:0] wb_writeReg,
    output logic [N-1:0]        wb_data,
    output logic                halted,
`ifdef MEMWB_PERF_EN
    output logic [31:0]         retired_count,
`endif
    output logic [1:0]          wb_state
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    localparam logic [3:0] DrainInit = 4'(HALT_DRAIN - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [N-1:0]        alu_q, alu_d;
    logic [15:0]         mem_q, mem_d;
    logic                mem_to_reg_q, mem_to_reg_d;
    logic                reg_write_q, reg_write_d;
    logic [REG_BITS-1:0] write_reg_q, write_reg_d;
    logic                load_en;

    // New contents are only accepted while running and neither flushed nor stalled.
    assign load_en = (state_q == StRun) && !flush && !stall;

    always_comb begin
        valid_d      = valid_q;
        alu_d        = alu_q;
        mem_d        = mem_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if ((state_q != StRun) || flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
        end

        if (load_en) begin
            alu_d        = aluResult;
            mem_d        = mem_data;
            mem_to_reg_d = memToReg;
            reg_write_d  = regWrite;
            write_reg_d  = writeReg;
        end

        unique case (state_q)
            StRun: begin
                if (load_en && in_valid && halt_in) begin
                    state_d = StDrain;
                    cnt_d   = DrainInit;
                end
            end
            StDrain: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            cnt_q        <= 4'd0;
            valid_q      <= 1'b0;
            alu_q        <= '0;
            mem_q        <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            alu_q        <= alu_d;
            mem_q        <= mem_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
        end
    end

    // Memory data is fitted to the datapath width: zero-extended or truncated.
    logic [N-1:0] mem_ext;
    generate
        if (N > 16) begin : g_mem_zext
            assign mem_ext = {{(N - 16){1'b0}}, mem_q};
        end else if (N == 16) begin : g_mem_same
            assign mem_ext = mem_q;
        end else begin : g_mem_trunc
            assign mem_ext = mem_q[N-1:0];
        end
    endgenerate

    assign wb_valid    = valid_q;
    assign wb_regWrite = valid_q & reg_write_q;
    assign wb_writeReg = write_reg_q;
    assign wb_data     = mem_to_reg_q ? mem_ext : alu_q;
    assign halted      = (state_q == StHalted);
    assign wb_state    = state_q;

`ifdef MEMWB_PERF_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (load_en && in_valid && (retired_q != 32'hFFFF_FFFF)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps plus randomized traffic against
// a reference model that tracks retirement and the halt point by edge count.
module tb_mem_wb_stage;

    localparam int unsigned N  = 16;
    localparam int unsigned RB = 3;
    localparam int          HD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  aluResult = '0;
    logic [15:0]   mem_data = '0;
    logic          memToReg = 1'b0;
    logic          regWrite = 1'b0;
    logic [RB-1:0] writeReg = '0;
    logic          halt_in = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic          wb_valid;
    logic          wb_regWrite;
    logic [RB-1:0] wb_writeReg;
    logic [N-1:0]  wb_data;
    logic          halted;
    logic [1:0]    wb_state;
`ifdef MEMWB_PERF_EN
    logic [31:0]   retired_count;
`endif

    mem_wb_stage #(
        .N          (N),
        .REG_BITS   (RB),
        .HALT_DRAIN (HD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .aluResult   (aluResult),
        .mem_data    (mem_data),
        .memToReg    (memToReg),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .halt_in     (halt_in),
        .stall       (stall),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_regWrite (wb_regWrite),
        .wb_writeReg (wb_writeReg),
        .wb_data     (wb_data),
        .halted      (halted),
`ifdef MEMWB_PERF_EN
        .retired_count (retired_count),
`endif
        .wb_state    (wb_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: last retired instruction plus the edge index at which HALT retired.
    logic          m_valid;
    logic [N-1:0]  m_alu;
    logic [15:0]   m_mem;
    logic          m_m2r;
    logic          m_rw;
    logic [RB-1:0] m_wr;
    int            edge_no;
    int            halt_edge;
    logic [31:0]   m_retired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_state();
        if (halt_edge < 0) return 0;
        if ((edge_no - halt_edge) < HD) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_alu     = '0;
        m_mem     = '0;
        m_m2r     = 1'b0;
        m_rw      = 1'b0;
        m_wr      = '0;
        edge_no   = 0;
        halt_edge = -1;
        m_retired = 32'd0;
    endtask

    task automatic model_edge();
        edge_no++;
        if ((halt_edge >= 0) || flush) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_alu   = aluResult;
            m_mem   = mem_data;
            m_m2r   = memToReg;
            m_rw    = regWrite;
            m_wr    = writeReg;
            if (in_valid && (m_retired != 32'hFFFF_FFFF)) m_retired = m_retired + 32'd1;
            if (in_valid && halt_in) halt_edge = edge_no;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(wb_valid), 32'(m_valid));
        chk({tag, ".regwrite"}, 32'(wb_regWrite), 32'(m_valid & m_rw));
        if (m_valid) begin
            chk({tag, ".wreg"}, 32'(wb_writeReg), 32'(m_wr));
            chk({tag, ".data"}, 32'(wb_data), m_m2r ? 32'(m_mem) : 32'(m_alu));
        end
        chk({tag, ".state"}, 32'(wb_state), 32'(exp_state()));
        chk({tag, ".halted"}, 32'(halted), 32'(exp_state() == 2));
`ifdef MEMWB_PERF_EN
        chk({tag, ".retired"}, retired_count, m_retired);
`endif
    endtask

    task automatic drive(input logic v, input logic [N-1:0] alu, input logic [15:0] mem,
                         input logic m2r, input logic rw, input logic [RB-1:0] wr,
                         input logic h, input logic s, input logic f);
        in_valid  = v;
        aluResult = alu;
        mem_data  = mem;
        memToReg  = m2r;
        regWrite  = rw;
        writeReg  = wr;
        halt_in   = h;
        stall     = s;
        flush     = f;
    endtask

    task automatic drive_rand(input int halt_mod);
        drive(1'($urandom), N'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              RB'($urandom), (halt_mod > 0) ? (($urandom % halt_mod) == 0) : 1'b0,
              ($urandom % 4) == 0, ($urandom % 6) == 0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset raised between edges must clear every output without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, ".data0"}, 32'(wb_data), 32'd0);
        chk({tag, ".wreg0"}, 32'(wb_writeReg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset_hold");
        chk("reset_hold.data0", 32'(wb_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step("first_load");
        chk("first_load.data_const", 32'(wb_data), 32'h1234);

        drive(1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step("mem_select");
        chk("mem_select.data_const", 32'(wb_data), 32'hBEEF);
        drive(1'b0, 16'h0040, 16'hBEEF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step("invalid_load");

        drive(1'b1, 16'h00AA, 16'h0000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step("load_aa");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0055, 16'h0000, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
            step("stall_hold");
        end
        chk("stall_hold.data_const", 32'(wb_data), 32'h00AA);
        drive(1'b1, 16'h0055, 16'h0000, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1);
        step("flush_stall");

        drive(1'b1, 16'hC0DE, 16'h1111, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        step("pre_reset");
        async_reset("rst_async");

        drive(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        step("halt_invalid");
        drive(1'b1, 16'h0002, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        step("halt_flushed");
        drive(1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
        step("halt_stalled");
        drive(1'b1, 16'h0004, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        step("halt_withdrawn");

        repeat (150) begin
            drive_rand(0);
            step("rand_run");
        end

        drive(1'b1, 16'h0777, 16'h0000, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        step("halt_load");
        repeat (6) begin
            drive(1'b1, N'($urandom), 16'($urandom), 1'b0, 1'b1, 3'd1, 1'b0,
                  1'($urandom), 1'($urandom));
            step("drain");
        end
        async_reset("rst_halted");

        drive(1'b1, 16'h0888, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        step("halt_load2");
        drive(1'b1, 16'h0999, 16'h0000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step("drain2");
        async_reset("rst_drain");

        repeat (300) begin
            if ((halt_edge >= 0) && ((edge_no - halt_edge) > HD + 2)) async_reset("rand_rst");
            drive_rand(12);
            step("rand_halt");
        end

`ifdef MEMWB_PERF_EN
        async_reset("perf_rst");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, N'(i), 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
            step("perf_load");
        end
        drive(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        step("perf_flush");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0200, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
            step("perf_stall");
        end
        chk("perf.count5", retired_count, 32'd5);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFF_FFFF;
        drive(1'b1, 16'h0300, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        step("perf_sat");
        chk("perf.saturate", retired_count, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
